// File: rtl/dense_layer_axil_regfile_pkg.sv
// Shared constants, FSM state types and the address decoder for the
// dense-layer AXI-Lite register file.
package dense_layer_axil_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [11:0] CTRL_BASE   = 12'h000;
  localparam logic [11:0] STAT_BASE   = 12'h100;
  localparam logic [11:0] ID_OFFSET   = 12'h1FC;
  localparam logic [15:0] ID_MAGIC    = 16'hD17E;
  localparam logic [31:0] DEADBEEF    = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {KIND_CTRL, KIND_STAT, KIND_ID, KIND_UNMAPPED} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [5:0] index;
  } decode_t;

  // Byte offsets; bits [1:0] are ignored and anything at or above bit 9 is unmapped.
  function automatic decode_t decode_addr(input logic [63:0] addr, input int num_ctrl,
                                          input int num_stat);
    logic [63:0] off;
    decode_t     d;
    off     = {addr[63:2], 2'b00};
    d.kind  = KIND_UNMAPPED;
    d.index = '0;
    if (off[63:9] == '0) begin
      if (off < 64'(CTRL_BASE) + 64'(4 * num_ctrl)) begin
        d.kind  = KIND_CTRL;
        d.index = off[7:2];
      end else if (off >= 64'(STAT_BASE) && off < 64'(STAT_BASE) + 64'(4 * num_stat)) begin
        d.kind  = KIND_STAT;
        d.index = 6'((off - 64'(STAT_BASE)) >> 2);
      end else if (off == 64'(ID_OFFSET)) begin
        d.kind = KIND_ID;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/dense_layer_axil_regfile_if.sv
// AXI-Lite bus bundle between the shell OCL (BAR0) master and the register file.
interface dense_layer_axil_regfile_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dense_layer_axil_regfile.sv
// AXI-Lite register file: byte-strobed control registers with write pulses,
// read-only status registers with optional 64-bit pair snapshots, and an ID word.
module dense_layer_axil_regfile
  import dense_layer_axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    NUM_CTRL     = 4,
  parameter int                    NUM_STAT     = 8,
  parameter logic [NUM_CTRL*32-1:0] CTRL_RST_VAL = '0,
  parameter bit                    SNAP_EN      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  dense_layer_axil_regfile_if.slave ocl,
  output logic [NUM_CTRL*32-1:0]   ctrl_q,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [NUM_STAT*32-1:0]   stat_d
);

  localparam int NUM_PAIR = SNAP_EN ? NUM_STAT / 2 : 0;
  localparam int NUM_SH   = (NUM_PAIR > 0) ? NUM_PAIR : 1;

  wr_state_e             wr_state_reg, wr_state_next;
  logic                  aw_held_reg, w_held_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic [31:0]           w_data_reg;
  logic [3:0]            w_strb_reg;
  logic [1:0]            bresp_reg;
  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  decode_t               wr_dec;
  logic [NUM_CTRL*32-1:0] ctrl_reg;

  assign aw_hs   = ocl.awvalid && ocl.awready;
  assign w_hs    = ocl.wvalid && ocl.wready;
  assign wr_addr = aw_held_reg ? aw_addr_reg : ocl.awaddr;
  assign wr_data = w_held_reg ? w_data_reg : ocl.wdata;
  assign wr_strb = w_held_reg ? w_strb_reg : ocl.wstrb;
  // Both halves available, either latched earlier or handshaking now.
  assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
  assign wr_dec  = decode_addr(64'(wr_addr), NUM_CTRL, NUM_STAT);

  always_ff @(posedge clk) begin
    if (rst) wr_state_reg <= WR_IDLE;
    else     wr_state_reg <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    unique case (wr_state_reg)
      WR_IDLE, WR_HAVE_AW, WR_HAVE_W: begin
        if (commit)                       wr_state_next = WR_RESP;
        else if (aw_held_reg || aw_hs)    wr_state_next = WR_HAVE_AW;
        else if (w_held_reg || w_hs)      wr_state_next = WR_HAVE_W;
        else                              wr_state_next = WR_IDLE;
      end
      WR_RESP: if (ocl.bready) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_comb begin
    ocl.awready = !aw_held_reg && (wr_state_reg != WR_RESP);
    ocl.wready  = !w_held_reg && (wr_state_reg != WR_RESP);
    ocl.bvalid  = (wr_state_reg == WR_RESP);
    ocl.bresp   = bresp_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bresp_reg   <= RESP_OKAY;
    end else if (commit) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      bresp_reg   <= (wr_dec.kind == KIND_CTRL) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_addr_reg <= ocl.awaddr;
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        w_data_reg <= ocl.wdata;
        w_strb_reg <= ocl.wstrb;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
      logic        hit;
      logic [31:0] word_reg;
      logic        pulse_reg;
      assign hit = commit && (wr_dec.kind == KIND_CTRL) && (wr_dec.index == 6'(gi));
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg  <= CTRL_RST_VAL[32*gi +: 32];
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          if (hit) begin
            for (int b = 0; b < 4; b++) begin
              if (wr_strb[b]) word_reg[8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end
      assign ctrl_reg[32*gi +: 32] = word_reg;
      assign ctrl_wr_pulse[gi]     = pulse_reg;
    end
  endgenerate

  assign ctrl_q = ctrl_reg;

  rd_state_e            rd_state_reg, rd_state_next;
  logic                 ar_hs;
  decode_t              ar_dec;
  logic [31:0]          rd_data, rdata_reg;
  logic [1:0]           rd_resp, rresp_reg;
  logic [NUM_SH*32-1:0] shadow_reg;

  assign ar_hs  = ocl.arvalid && ocl.arready;
  assign ar_dec = decode_addr(64'(ocl.araddr), NUM_CTRL, NUM_STAT);

  always_ff @(posedge clk) begin
    if (rst) rd_state_reg <= RD_IDLE;
    else     rd_state_reg <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    unique case (rd_state_reg)
      RD_IDLE: if (ar_hs)      rd_state_next = RD_DATA;
      RD_DATA: if (ocl.rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    ocl.arready = (rd_state_reg == RD_IDLE);
    ocl.rvalid  = (rd_state_reg == RD_DATA);
    ocl.rdata   = rdata_reg;
    ocl.rresp   = rresp_reg;
  end

  // Odd member of a pair reads the word captured by the preceding even read.
  always_comb begin
    rd_data = DEADBEEF;
    rd_resp = RESP_SLVERR;
    unique case (ar_dec.kind)
      KIND_CTRL: begin
        rd_resp = RESP_OKAY;
        rd_data = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (ar_dec.index == 6'(i)) rd_data = ctrl_reg[32*i +: 32];
        end
      end
      KIND_STAT: begin
        rd_resp = RESP_OKAY;
        rd_data = '0;
        for (int i = 0; i < NUM_STAT; i++) begin
          if (ar_dec.index == 6'(i)) begin
            if ((i % 2) == 1 && (i / 2) < NUM_PAIR) rd_data = shadow_reg[32*((i/2) % NUM_SH) +: 32];
            else                                     rd_data = stat_d[32*i +: 32];
          end
        end
      end
      KIND_ID: begin
        rd_resp = RESP_OKAY;
        rd_data = {ID_MAGIC, 8'(NUM_CTRL), 8'(NUM_STAT)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_data;
      rresp_reg <= rd_resp;
    end
  end

  generate
    for (gi = 0; gi < NUM_SH; gi++) begin : g_shadow
      if (gi < NUM_PAIR) begin : g_live
        logic [31:0] word_reg;
        always_ff @(posedge clk) begin
          if (rst) word_reg <= '0;
          else if (ar_hs && ar_dec.kind == KIND_STAT && ar_dec.index == 6'(2*gi))
            word_reg <= stat_d[32*(2*gi+1) +: 32];
        end
        assign shadow_reg[32*gi +: 32] = word_reg;
      end else begin : g_none
        assign shadow_reg[32*gi +: 32] = '0;
      end
    end
  endgenerate

endmodule

// File: doc/dense_layer_axil_regfile.md
# dense_layer_axil_regfile

Parametrised AXI-Lite register file that replaces the fixed dense-layer BAR0 slave. It provides NUM_CTRL read/write control registers with byte-strobe writes and per-register write pulses, plus NUM_STAT read-only status registers with coherent 64-bit snapshot reads. It accepts AW and W in either order, flags unmapped or illegal accesses with SLVERR, and sits between the shell OCL (BAR0) interface and the dense-layer control and status logic.

## Interface
- ADDR_WIDTH, 32: AXI-Lite address width.
- NUM_CTRL, 4: number of R/W control registers; legal range 1..64.
- NUM_STAT, 8: number of read-only status registers; legal range 1..63.
- CTRL_RST_VAL, '0: NUM_CTRL*32-bit flat vector; word i is the reset value of control register i.
- SNAP_EN, 1: enables the 64-bit snapshot on status pairs.
- clk  in  1  sole clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- ocl_awaddr/awvalid/awready, ocl_wdata/wstrb/wvalid/wready, ocl_bresp/bvalid/bready: AXI-Lite write channels; widths ADDR_WIDTH/1/1, 32/4/1/1, 2/1/1.
- ocl_araddr/arvalid/arready, ocl_rdata/rresp/rvalid/rready: AXI-Lite read channels; widths ADDR_WIDTH/1/1, 32/2/1/1.
- ctrl_q  out  NUM_CTRL*32  current control register contents; word i is at [32i+:32].
- ctrl_wr_pulse  out  NUM_CTRL  one-cycle pulse on each successful write to control register i.
- stat_d  in  NUM_STAT*32  status inputs, sampled at read time.

## Operation
- Decode ignores addr[1:0]. Control register i is at 0x000+4i. Status register j is at 0x100+4j. The ID register is at 0x1FC and reads {16'hD17E, NUM_CTRL[7:0], NUM_STAT[7:0]}. Any other offset, or any nonzero bit at or above bit 9, is unmapped.
- Control write:
  - Each byte lane b with wstrb[b]=1 updates that byte; other bytes hold.
  - bresp is OKAY (00).
  - wstrb=0 is OKAY with no change, and ctrl_wr_pulse still fires.
- Write to a status, ID or unmapped address: no state change, no pulse, bresp is SLVERR (10).
- Read of a control, status or ID register returns the value with rresp OKAY. A read of an unmapped address returns 32'hDEAD_BEEF with rresp SLVERR.
- Snapshot (SNAP_EN=1), for status pair (2k, 2k+1):
  - A read of 2k also latches stat_d word 2k+1 into shadow register k.
  - A read of 2k+1 returns shadow k.
  - Shadows reset to 0.
  - With SNAP_EN=0, 2k+1 reads live stat_d.
  - If NUM_STAT is odd, the last register has no shadow and reads live.
- Write FSM uses aw_held and w_held flags plus latched address, data and strobe:
  - States: IDLE, HAVE_AW, HAVE_W, RESP.
  - Commit happens when both address and data are available, whether latched or presented this cycle. Commit goes to RESP.
  - RESP returns to IDLE on bready.
- Read FSM: states IDLE and DATA. DATA returns to IDLE on rready.

## Timing
- Reset values:
  - awready=1, wready=1, arready=1; bvalid=0, rvalid=0.
  - bresp=00, rresp=00, rdata=0.
  - ctrl_q=CTRL_RST_VAL, ctrl_wr_pulse=0.
- awready is high only when !aw_held && state!=RESP. wready is high only when !w_held && state!=RESP.
- AW and W handshaken in the same cycle N: register update, ctrl_wr_pulse and bvalid all become visible in cycle N+1.
- AW and W in different cycles: commit is on the edge of the later handshake, and outputs change the next cycle.
- bvalid and bresp are held stable until bready. No new AW or W is accepted during RESP. A bready already high at bvalid gives one-cycle RESP.
- arready is high in IDLE only. An AR handshake in cycle N gives registered rdata, rresp and rvalid in N+1. These are held stable until rready; stat_d is not resampled.
- Write and read paths are independent. A same-cycle write commit and read of the same control register returns the pre-write value.
- Synchronous rst during any transaction:
  - Next cycle all valids are 0 and held flags are cleared.
  - Registers and shadows return to reset values.
  - The pending transaction is dropped with no response.

## Structure
- Package dense_layer_axil_pkg holds:
  - AXI resp constants (RESP_OKAY, RESP_SLVERR).
  - CTRL_BASE=0x000, STAT_BASE=0x100, ID_OFFSET=0x1FC, ID_MAGIC=16'hD17E, DEADBEEF constant.
  - FSM state enums.
  - Decode function returning {kind, index}, with kind in CTRL/STAT/ID/UNMAPPED.
- Single module; no sub-module is warranted.

## Test plan
- Reset, then read 0x000 with CTRL_RST_VAL word0=0x12345678 -> rdata 0x12345678, rresp 00; rvalid rises 1 cycle after the AR handshake.
- AW(0x004) in cycle 0, W(0xAABBCCDD, strb 4'b0101) in cycle 3 -> ctrl word1 = 0x00BB00DD, ctrl_wr_pulse[1] high only in cycle 4, bvalid in cycle 4, bresp 00.
- W before AW, with bready held low 5 cycles -> bvalid is stable for those 5 cycles, awready=wready=0, and a second AW is not accepted until after B completes.
- Write to 0x100 and to 0x0F0 (NUM_CTRL=4) -> bresp 10, no pulse, ctrl_q unchanged. Read 0x180 -> 0xDEADBEEF, rresp 10. Read 0x1FC -> 0xD17E0408.
- Snapshot: stat_d word0=1, word1=0x55. Read 0x100, then change word1 to 0x66, then read 0x104 -> 0x55. A second read of 0x100 followed by 0x104 -> 0x66.
- Assert rst while W is latched and AW is pending -> next cycle bvalid=0, ctrl_q = reset values; a subsequent full write completes normally.
